// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto a byte-wide synchronous RAM.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break; otherwise MEM wins every tie.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [2:0]  n_reg, n_next;
    logic [31:0] base_reg, base_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] data_reg, data_next;
    logic        sel_mem_reg, sel_mem_next;
    logic        if_done_reg, if_done_next;
    logic        mem_done_reg, mem_done_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic [31:0] mem_rdata_reg, mem_rdata_next;
    logic        ram_rw_reg, ram_rw_next;
    logic [31:0] ram_addr_reg, ram_addr_next;
    logic [7:0]  ram_dout_reg, ram_dout_next;

    logic        tie_to_mem;
    logic        grant_mem;
    logic [2:0]  mem_nbytes;
    logic [1:0]  cap_idx;
    logic [31:0] data_merged;
    logic [7:0]  wbyte [4];

`ifdef MEM_ARB_RR_EN
    logic last_mem_reg, last_mem_next;
    assign tie_to_mem = ~last_mem_reg;
`else
    assign tie_to_mem = 1'b1;
`endif

    assign grant_mem = mem_req & (~if_req | tie_to_mem);

    always_comb begin
        case (mem_len)
            2'b00:   mem_nbytes = 3'd1;
            2'b01:   mem_nbytes = 3'd2;
            default: mem_nbytes = 3'd4;
        endcase
    end

    // byte i arrives two edges after its address was issued, i.e. when cnt = i+2
    assign cap_idx = cnt_reg[1:0] - 2'd2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign data_merged[8*gi +: 8] = (cap_idx == 2'(gi)) ? ram_din : data_reg[8*gi +: 8];
            assign wbyte[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        n_next         = n_reg;
        base_next      = base_reg;
        wdata_next     = wdata_reg;
        data_next      = data_reg;
        sel_mem_next   = sel_mem_reg;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        ram_rw_next    = ram_rw_reg;
        ram_addr_next  = ram_addr_reg;
        ram_dout_next  = ram_dout_reg;
`ifdef MEM_ARB_RR_EN
        last_mem_next  = last_mem_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (if_req || mem_req) begin
                    sel_mem_next  = grant_mem;
                    base_next     = grant_mem ? mem_addr : if_addr;
                    ram_addr_next = grant_mem ? mem_addr : if_addr;
                    n_next        = grant_mem ? mem_nbytes : 3'd4;
                    wdata_next    = mem_wdata;
                    data_next     = '0;
                    cnt_next      = 3'd1;
`ifdef MEM_ARB_RR_EN
                    last_mem_next = grant_mem;
`endif
                    if (grant_mem && mem_we) begin
                        state_next    = WR;
                        ram_rw_next   = 1'b1;
                        ram_dout_next = mem_wdata[7:0];
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg < n_reg)
                    ram_addr_next = base_reg + {29'd0, cnt_reg};
                if (cnt_reg >= 3'd2)
                    data_next = data_merged;
                if (cnt_reg == n_reg + 3'd1) begin
                    state_next = FIN;
                    if (sel_mem_reg) begin
                        mem_done_next  = 1'b1;
                        mem_rdata_next = data_merged;
                    end else begin
                        if_done_next  = 1'b1;
                        if_rdata_next = data_merged;
                    end
                end
            end
            WR: begin
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == n_reg) begin
                    state_next    = FIN;
                    ram_rw_next   = 1'b0;
                    mem_done_next = 1'b1;
                end else begin
                    ram_addr_next = base_reg + {29'd0, cnt_reg};
                    ram_dout_next = wbyte[cnt_reg[1:0]];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            n_reg         <= '0;
            base_reg      <= '0;
            wdata_reg     <= '0;
            data_reg      <= '0;
            sel_mem_reg   <= 1'b0;
            if_done_reg   <= 1'b0;
            mem_done_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            ram_rw_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_dout_reg  <= '0;
`ifdef MEM_ARB_RR_EN
            last_mem_reg  <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            n_reg         <= n_next;
            base_reg      <= base_next;
            wdata_reg     <= wdata_next;
            data_reg      <= data_next;
            sel_mem_reg   <= sel_mem_next;
            if_done_reg   <= if_done_next;
            mem_done_reg  <= mem_done_next;
            if_rdata_reg  <= if_rdata_next;
            mem_rdata_reg <= mem_rdata_next;
            ram_rw_reg    <= ram_rw_next;
            ram_addr_reg  <= ram_addr_next;
            ram_dout_reg  <= ram_dout_next;
`ifdef MEM_ARB_RR_EN
            last_mem_reg  <= last_mem_next;
`endif
        end
    end

    assign if_done   = if_done_reg;
    assign mem_done  = mem_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_rdata = mem_rdata_reg;
    assign ram_rw    = ram_rw_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_dout  = ram_dout_reg;

endmodule
